np_run_ctrl: RTL and testbench



---
 rtl/np_run_ctrl.sv | 150 +++++++++++++++
 tb/tb_np_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/np_run_ctrl.sv
// Run sequencer for the np core: holds the core in reset while a host streams a
// program into instruction memory, releases it, then watches for halt or watchdog timeout.
module np_run_ctrl #(
    parameter int WIDTH        = 32,
    parameter int ADDRSIZE     = 12,
    parameter int CNT_W        = 24,
    parameter int RESET_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    max_cycles,
    input  logic                load_valid,
    input  logic [WIDTH-1:0]    load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                imem_wr,
    output logic [ADDRSIZE-1:0] imem_addr,
    output logic [WIDTH-1:0]    imem_data,
    output logic                cpu_reset,
    input  logic                cpu_halt,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [ADDRSIZE:0]   load_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PRIME = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_TOUT  = 3'd5;

    localparam int PR_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [PR_W-1:0] PRIME_LAST = PR_W'(RESET_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [PR_W-1:0]     prime_cnt_q, prime_cnt_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [ADDRSIZE:0]   load_count_q, load_count_d;
    logic                imem_wr_q, imem_wr_d;
    logic [ADDRSIZE-1:0] imem_addr_q, imem_addr_d;
    logic [WIDTH-1:0]    imem_data_q, imem_data_d;
    logic                cpu_reset_q, cpu_reset_d;

    // The write pointer always equals the words written so far, so it is the low bits of load_count.
    logic [ADDRSIZE-1:0] wr_ptr;
    assign wr_ptr = load_count_q[ADDRSIZE-1:0];

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d       = state_q;
        prime_cnt_d   = prime_cnt_q;
        max_d         = max_q;
        cycle_count_d = cycle_count_q;
        load_count_d  = load_count_q;
        imem_wr_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_data_d   = imem_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start) begin
                    state_d       = S_LOAD;
                    cycle_count_d = '0;
                    load_count_d  = '0;
                    max_d         = max_cycles;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    imem_wr_d    = 1'b1;
                    imem_addr_d  = wr_ptr;
                    imem_data_d  = load_data;
                    load_count_d = load_count_q + 1'b1;
                    if (load_last || (wr_ptr == {ADDRSIZE{1'b1}})) begin
                        state_d     = S_PRIME;
                        prime_cnt_d = '0;
                    end
                end
            end
            S_PRIME: begin
                if (prime_cnt_q == PRIME_LAST) state_d = S_RUN;
                else                           prime_cnt_d = prime_cnt_q + 1'b1;
            end
            S_RUN: begin
                // The count includes the cycle in which halt or timeout is decided.
                if (cycle_count_q != {CNT_W{1'b1}}) cycle_count_d = cycle_count_q + 1'b1;
                if (cpu_halt)
                    state_d = S_DONE;
                else if ((max_q != '0) && (CNT_W'(cycle_count_q + 1'b1) == max_q))
                    state_d = S_TOUT;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d       = S_IDLE;
            imem_wr_d     = 1'b0;
            imem_addr_d   = imem_addr_q;
            imem_data_d   = imem_data_q;
            cycle_count_d = cycle_count_q;
            load_count_d  = load_count_q;
            max_d         = max_q;
        end

        cpu_reset_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= S_IDLE;
            prime_cnt_q   <= '0;
            max_q         <= '0;
            cycle_count_q <= '0;
            load_count_q  <= '0;
            imem_wr_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_data_q   <= '0;
            cpu_reset_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            prime_cnt_q   <= prime_cnt_d;
            max_q         <= max_d;
            cycle_count_q <= cycle_count_d;
            load_count_q  <= load_count_d;
            imem_wr_q     <= imem_wr_d;
            imem_addr_q   <= imem_addr_d;
            imem_data_q   <= imem_data_d;
            cpu_reset_q   <= cpu_reset_d;
        end
    end

    assign load_ready  = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD) || (state_q == S_PRIME) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign timeout     = (state_q == S_TOUT);
    assign imem_wr     = imem_wr_q;
    assign imem_addr   = imem_addr_q;
    assign imem_data   = imem_data_q;
    assign cpu_reset   = cpu_reset_q;
    assign cycle_count = cycle_count_q;
    assign load_count  = load_count_q;

endmodule

// File: tb/tb_np_run_ctrl.sv
// Self-checking bench for np_run_ctrl: table-driven sessions, randomized sessions
// against an outcome model, and hand-written sequences for full memory, abort and reset.
module tb_np_run_ctrl;

    localparam int WIDTH        = 32;
    localparam int ADDRSIZE     = 12;
    localparam int CNT_W        = 24;
    localparam int RESET_CYCLES = 2;
    localparam int MEMSIZE      = 1 << ADDRSIZE;

    logic                clk = 1'b0;
    logic                reset, start, abort, load_valid, load_last, cpu_halt;
    logic [CNT_W-1:0]    max_cycles;
    logic [WIDTH-1:0]    load_data;
    logic                load_ready, imem_wr, cpu_reset, busy, done, timeout;
    logic [ADDRSIZE-1:0] imem_addr;
    logic [WIDTH-1:0]    imem_data;
    logic [CNT_W-1:0]    cycle_count;
    logic [ADDRSIZE:0]   load_count;

    np_run_ctrl #(
        .WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .max_cycles(max_cycles),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .imem_wr(imem_wr), .imem_addr(imem_addr),
        .imem_data(imem_data), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .busy(busy),
        .done(done), .timeout(timeout), .cycle_count(cycle_count), .load_count(load_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and reset-release monitor, sampled mid-cycle.
    logic [ADDRSIZE-1:0] wr_addr_q[$];
    logic [WIDTH-1:0]    wr_data_q[$];
    int   last_wr_cyc    = 0;
    int   rst_fall_cyc   = 0;
    int   addr0_writes   = 0;
    logic prev_cpu_reset = 1'b1;

    always @(negedge clk) begin
        if (imem_wr) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
            last_wr_cyc <= cyc;
            if (imem_addr == '0) addr0_writes <= addr0_writes + 1;
        end
        if (prev_cpu_reset && !cpu_reset) rst_fall_cyc <= cyc;
        prev_cpu_reset <= cpu_reset;
    end

    logic [WIDTH-1:0] prog[MEMSIZE];

    typedef struct {
        int               nwords;
        logic [CNT_W-1:0] maxc;
        int               halt_at;
        bit               fixed_prog;
        bit               exp_done;
        int               exp_count;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outcome from the rules alone: halt wins ties, otherwise the watchdog fires at max.
    function automatic void ref_outcome(input int halt_at, input int maxc,
                                        output bit exp_done, output int exp_count);
        if (halt_at != 0 && (maxc == 0 || halt_at <= maxc)) begin
            exp_done  = 1'b1;
            exp_count = halt_at;
        end else begin
            exp_done  = 1'b0;
            exp_count = maxc;
        end
    endfunction

    task automatic run_session(input string tag, input int nwords, input logic [CNT_W-1:0] maxc,
                               input int halt_at, input bit gaps,
                               input bit exp_done, input int exp_count);
        int base;
        int k;
        bit exited;
        base = wr_addr_q.size();
        start = 1'b1; max_cycles = maxc;
        tick();
        start = 1'b0; max_cycles = $urandom;
        check({tag, ":load_ready"}, load_ready, 1);
        check({tag, ":cleared_cnt"}, {cycle_count, load_count}, 0);
        for (int i = 0; i < nwords; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    load_valid = 1'b0; load_last = 1'($urandom_range(0, 1)); load_data = $urandom;
                    tick();
                end
            end
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == nwords - 1);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        check({tag, ":prime"}, {busy, load_ready, cpu_reset}, 3'b101);
        for (int w = 0; w < RESET_CYCLES + 4 && cpu_reset; w++) tick();
        check({tag, ":released"}, cpu_reset, 0);
        exited = 1'b0;
        for (k = 1; k <= exp_count + 8; k++) begin
            cpu_halt = (k == halt_at);
            tick();
            if (!busy) begin
                exited = 1'b1;
                break;
            end
        end
        cpu_halt = 1'b0;
        check({tag, ":exited"}, exited, 1);
        if (!exited) begin
            abort = 1'b1; tick(); abort = 1'b0;
        end else begin
            check({tag, ":run_len"}, k, exp_count);
        end
        check({tag, ":done"}, done, exp_done);
        check({tag, ":timeout"}, timeout, !exp_done);
        check({tag, ":cycle_count"}, cycle_count, exp_count);
        check({tag, ":frozen"}, cpu_reset, 1);
        check({tag, ":load_count"}, load_count, nwords);
        check({tag, ":release_gap"}, rst_fall_cyc - last_wr_cyc, RESET_CYCLES);
        check({tag, ":n_writes"}, wr_addr_q.size() - base, nwords);
        for (int i = 0; i < nwords && base + i < wr_addr_q.size(); i++) begin
            check({tag, ":wr_addr"}, wr_addr_q[base + i], i);
            check({tag, ":wr_data"}, wr_data_q[base + i], prog[i]);
        end
        tick(); tick();
        if (exited) check({tag, ":count_hold"}, cycle_count, exp_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base, a0, nw, mc, ha, ec;
        bit ed;

        vecs[0] = '{3, 0, 9, 1, 1, 9};
        vecs[1] = '{1, 20, 0, 0, 0, 20};
        vecs[2] = '{2, 5, 5, 0, 1, 5};
        vecs[3] = '{4, 5, 6, 0, 0, 5};
        vecs[4] = '{5, 1, 0, 0, 0, 1};
        vecs[5] = '{2, 1, 1, 0, 1, 1};
        vecs[6] = '{6, 0, 1, 0, 1, 1};
        vecs[7] = '{3, 10, 4, 0, 1, 4};

        reset = 1'b1; start = 1'b0; abort = 1'b0; max_cycles = '0; load_valid = 1'b0;
        load_data = '0; load_last = 1'b0; cpu_halt = 1'b0;
        tick(); tick();
        check("rst:ctrl", {cpu_reset, imem_wr, load_ready, busy, done, timeout}, 6'b100000);
        check("rst:data", {imem_addr, imem_data, cycle_count, load_count}, 0);
        reset = 1'b0;
        tick();
        check("idle:hold", {cpu_reset, busy, load_ready}, 3'b100);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].nwords; i++) prog[i] = $urandom;
            if (vecs[v].fixed_prog) begin
                prog[0] = 32'h3100_0000; prog[1] = 32'hB000_0000; prog[2] = 32'h0;
            end
            run_session($sformatf("vec%0d", v), vecs[v].nwords, vecs[v].maxc, vecs[v].halt_at,
                        v[0], vecs[v].exp_done, vecs[v].exp_count);
        end

        for (int r = 0; r < 12; r++) begin
            nw = $urandom_range(1, 20);
            mc = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            ha = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            if (mc == 0 && ha == 0) ha = $urandom_range(1, 40);
            for (int i = 0; i < nw; i++) prog[i] = $urandom;
            ref_outcome(ha, mc, ed, ec);
            run_session($sformatf("rnd%0d", r), nw, CNT_W'(mc), ha, 1'b1, ed, ec);
        end

        // Full memory: no load_last, valid every other cycle, no wrap to address 0.
        base = wr_addr_q.size(); a0 = addr0_writes;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < MEMSIZE; i++) begin
            load_valid = 1'b0; tick();
            load_valid = 1'b1; load_data = WIDTH'(i) ^ 32'hA5A5_0000; tick();
        end
        check("full:prime", {busy, load_ready, cpu_reset}, 3'b101);
        check("full:load_count", load_count, MEMSIZE);
        check("full:last_wr", {imem_wr, imem_addr}, {1'b1, 12'hFFF});
        tick(); tick();
        load_valid = 1'b0;
        check("full:n_writes", wr_addr_q.size() - base, MEMSIZE);
        check("full:addr0_once", addr0_writes - a0, 1);
        check("full:final_addr", wr_addr_q[wr_addr_q.size() - 1], 12'hFFF);
        abort = 1'b1; tick(); abort = 1'b0;
        check("full:abort", {busy, cpu_reset}, 2'b01);

        // Abort in LOAD after two words; the abort edge also carries a valid word.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 32'h1000 + i; tick();
        end
        abort = 1'b1; tick(); abort = 1'b0; load_valid = 1'b0;
        check("abort:idle", {busy, load_ready, cpu_reset, imem_wr}, 4'b0010);
        check("abort:load_count", load_count, 2);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("abort:beats_start", {busy, load_count}, {1'b0, 13'd2});
        for (int i = 0; i < 4; i++) prog[i] = $urandom;
        run_session("after_abort", 4, 7, 3, 1'b0, 1'b1, 3);

        // Reset mid-RUN, with an ignored start while running.
        start = 1'b1; max_cycles = '0; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 32'hDEAD_0000 + i; load_last = (i == 2); tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int w = 0; w < RESET_CYCLES + 4 && cpu_reset; w++) tick();
        tick(); tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        check("run:start_ignored", {busy, cpu_reset, load_ready}, 3'b100);
        check("run:count", cycle_count, 4);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst:ctrl", {cpu_reset, imem_wr, load_ready, busy, done, timeout}, 6'b100000);
        check("midrst:data", {imem_addr, imem_data, cycle_count, load_count}, 0);
        for (int i = 0; i < 2; i++) prog[i] = $urandom;
        run_session("after_rst", 2, 3, 0, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
